// File: rtl/sqrt_mag_sched_if.sv
// Request, sqrt-core and magnitude-result signals for the sqrt magnitude scheduler.
interface sqrt_mag_sched_if #(
  parameter int unsigned NCH = 4
);
  localparam int unsigned CHW = $clog2(NCH);

  logic [NCH-1:0]   req_valid;
  logic [NCH-1:0]   req_ready;
  logic [NCH*8-1:0] req_i;
  logic [NCH*8-1:0] req_q;

  logic             sqrt_en;
  logic [15:0]      sqrt_din;
  logic             sqrt_valid;
  logic [7:0]       sqrt_out;
  logic [15:0]      sqrt_remain;

  logic             mag_valid;
  logic             mag_ready;
  logic [7:0]       mag_out;
  logic [15:0]      mag_rem;
  logic [CHW-1:0]   mag_ch;

  // Scheduler side
  modport master (
    input  req_valid, req_i, req_q, sqrt_valid, sqrt_out, sqrt_remain, mag_ready,
    output req_ready, sqrt_en, sqrt_din, mag_valid, mag_out, mag_rem, mag_ch
  );

  // Requesters, sqrt core and consumer side
  modport slave (
    output req_valid, req_i, req_q, sqrt_valid, sqrt_out, sqrt_remain, mag_ready,
    input  req_ready, sqrt_en, sqrt_din, mag_valid, mag_out, mag_rem, mag_ch
  );
endinterface

// File: rtl/sqrt_mag_sched.sv
// Round-robin scheduler sharing one iterative sqrt core among NCH I/Q requesters.
// One job in flight at a time; a new sqrt_en would restart the core.
module sqrt_mag_sched #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  sqrt_mag_sched_if.master bus,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned CHW = $clog2(NCH);
  localparam int unsigned TW  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SQR   = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CHW-1:0]    rr_ptr;
  logic [CHW-1:0]    job_ch;
  logic signed [7:0] i_lat;
  logic signed [7:0] q_lat;
  logic [TW-1:0]     timer;

  logic              gnt_any;
  logic [CHW-1:0]    gnt_idx;
  logic [CHW-1:0]    cand;
  logic              slot_free_c;
  logic              grant_c;
  logic              done_c;
  logic              expire_c;
  logic [NCH-1:0]    req_ready_c;
  logic signed [15:0] i_ext;
  logic signed [15:0] q_ext;
  logic [15:0]       i_sq;
  logic [15:0]       q_sq;
  logic [15:0]       sq_sum_c;

  assign bus.req_ready = req_ready_c;

  // First requesting channel strictly after rr_ptr, circularly
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = CHW'((32'(rr_ptr) + k) % NCH);
      if (!gnt_any && bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // I^2 + Q^2 of the latched sample; max 32768 so 16 bits never overflow
  always_comb begin
    i_ext    = 16'(i_lat);
    q_ext    = 16'(q_lat);
    i_sq     = i_ext * i_ext;
    q_sq     = q_ext * q_ext;
    sq_sum_c = i_sq + q_sq;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_c) state_nxt = S_SQR;
      S_SQR:   state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (done_c || expire_c) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant, completion and abandon strobes; req_ready is held low during reset
  always_comb begin
    slot_free_c = !bus.mag_valid || bus.mag_ready;
    grant_c     = 1'b0;
    done_c      = 1'b0;
    expire_c    = 1'b0;
    req_ready_c = '0;
    case (state)
      S_IDLE: begin
        grant_c = rst_n && slot_free_c && gnt_any;
        if (grant_c) req_ready_c = NCH'(1) << gnt_idx;
      end
      S_WAIT: begin
        done_c   = bus.sqrt_valid;
        expire_c = !bus.sqrt_valid && (timer == TW'(TIMEOUT - 1));
      end
      default: ;
    endcase
  end

  // Job capture, core interface, result slot and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= CHW'(NCH - 1);
      job_ch        <= '0;
      i_lat         <= '0;
      q_lat         <= '0;
      timer         <= '0;
      bus.sqrt_en   <= 1'b0;
      bus.sqrt_din  <= '0;
      bus.mag_valid <= 1'b0;
      bus.mag_out   <= '0;
      bus.mag_rem   <= '0;
      bus.mag_ch    <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      bus.sqrt_en <= (state == S_SQR);
      busy        <= (state_nxt != S_IDLE);
      timeout_err <= expire_c;

      if (grant_c) begin
        job_ch <= gnt_idx;
        i_lat  <= bus.req_i[{gnt_idx, 3'b000} +: 8];
        q_lat  <= bus.req_q[{gnt_idx, 3'b000} +: 8];
      end

      if (state == S_SQR) bus.sqrt_din <= sq_sum_c;

      if (state == S_ISSUE) begin
        timer <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + TW'(1);
      end

      if (done_c) begin
        bus.mag_valid <= 1'b1;
        bus.mag_out   <= bus.sqrt_out;
        bus.mag_rem   <= bus.sqrt_remain;
        bus.mag_ch    <= job_ch;
      end else if (bus.mag_valid && bus.mag_ready) begin
        bus.mag_valid <= 1'b0;
      end

      if (done_c || expire_c) rr_ptr <= job_ch;
    end
  end

endmodule
